// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_pkg
//  Description : Shared types and constants for the MMU register read path.
//                Holds the page-table type codes, the PTE size encodings,
//                the page-table attribute layout, the register-group decode
//                and the response record carried by the response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmu_pkg;

    // Widest response the read path can produce (four 64-bit words).
    localparam int MMU_RESP_W = 256;

    // Page-table type code that selects 4-byte page-table entries.
    localparam logic [3:0] I386 = 4'd1;

    // PTE size encodings: log2 of the entry size in bytes.
    localparam logic [1:0] _4B_PTE = 2'd2;
    localparam logic [1:0] _8B_PTE = 2'd3;

    // Page-table attribute register; the type code sits in the low nibble.
    typedef struct packed {
        logic [59:0] attr;
        logic [3:0]  typ;
    } ptattr_t;

    // Register groups reachable through the register window.
    typedef enum logic [2:0] {
        MMU_RG_FAULT  = 3'd0,
        MMU_RG_PTBR   = 3'd1,
        MMU_RG_PROBE  = 3'd2,
        MMU_RG_PVALID = 3'd3,
        MMU_RG_PBL    = 3'd4,
        MMU_RG_REGION = 3'd5,
        MMU_RG_NONE   = 3'd7
    } mmu_rg_e;

    // One entry of the response FIFO.
    typedef struct packed {
        logic [MMU_RESP_W-1:0] dat;
        logic [15:0]           tid;
        logic [3:0]            pri;
        logic                  err;
    } mmu_rd_resp_t;

    localparam int MMU_RESP_BITS = $bits(mmu_rd_resp_t);

    // Map a register-window byte address onto its register group.
    function automatic mmu_rg_e mmu_rg_decode(input logic [13:0] adr);
        mmu_rg_e grp;
        casez (adr)
            14'b11_1111_000?_????: grp = MMU_RG_FAULT;
            14'b11_1111_001?_????: grp = MMU_RG_PTBR;
            14'b11_1111_010?_????: grp = MMU_RG_PROBE;
            14'b11_1111_011?_????: grp = MMU_RG_PVALID;
            14'b11_1011_0???_????: grp = MMU_RG_PBL;
            14'b11_1100_00??_????: grp = MMU_RG_REGION;
            default:               grp = MMU_RG_NONE;
        endcase
        return grp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_resp_fifo
//  Description : Response FIFO for the MMU register read path. Two write
//                ports per cycle (wr0 is stored ahead of wr1 when both fire),
//                one combinational read port. Pointers wrap modulo RDEPTH.
//  Ports       : clk, rst      clock / asynchronous active-high reset
//                wr0_en/data   first write port (config-space completions)
//                wr1_en/data   second write port (register reads)
//                rd_en         pop the head entry (only while not empty)
//                rd_data       head entry
//                not_empty     FIFO holds at least one entry
//                count         number of entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module mmu_resp_fifo
    import mmu_pkg::*;
#(
    parameter int RDEPTH = 4
)
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr0_en,
    input  logic [MMU_RESP_BITS-1:0]         wr0_data,
    input  logic                             wr1_en,
    input  logic [MMU_RESP_BITS-1:0]         wr1_data,
    input  logic                             rd_en,
    output logic [MMU_RESP_BITS-1:0]         rd_data,
    output logic                             not_empty,
    output logic [$clog2(RDEPTH):0]          count
);

    localparam int PW = $clog2(RDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] c_depth = (CW+1)'(RDEPTH);

    logic [MMU_RESP_BITS-1:0] r_mem [RDEPTH];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [CW-1:0]            r_count;

    logic [1:0]               w_nwr;
    logic [PW-1:0]            w_wa1;
    logic [CW-1:0]            w_count_nxt;
    logic [CW:0]              w_fill;
    logic                     w_ovf;

    assign w_nwr = {1'b0, wr0_en} + {1'b0, wr1_en};

    // wr1 lands just behind wr0 when both write in the same cycle.
    assign w_wa1 = wr0_en ? (r_wptr + PW'(1)) : r_wptr;

    assign w_count_nxt = r_count + CW'(w_nwr) - CW'(rd_en);

    // Occupancy after this cycle, one bit wider so an overflow is visible.
    assign w_fill = {1'b0, r_count} + (CW+1)'(w_nwr) - (CW+1)'(rd_en);
    assign w_ovf  = (w_fill > c_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < RDEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr0_en) begin
                r_mem[r_wptr] <= wr0_data;
            end
            if (wr1_en) begin
                r_mem[w_wa1] <= wr1_data;
            end
            r_wptr <= r_wptr + PW'(w_nwr);
            if (rd_en) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    assign rd_data   = r_mem[r_rptr];
    assign not_empty = (r_count != '0);
    assign count     = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !w_ovf);
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && (r_count == '0)));

endmodule
`default_nettype wire

// File: rtl/mmu_reg_read_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_reg_read_pipe
//  Description : Pipelined, back-pressured read path for the MMU register
//                window and config space. A request is registered in S0,
//                the addressed group is built and pushed into the response
//                FIFO in S1; config completions enter the FIFO directly.
//  Ports       : clk, rst                 clock / async active-high reset
//                req_v/req_rdy/req_adr/req_tid/req_pri   read request
//                cfg_ack/cfg_dat/cfg_tid  config-space completion (no stall)
//                fault_adr/seg/asid/v     fault record, fault_clr clears it
//                ptbr, ptattr             page table base / attributes
//                virt_adr/phys_adr/phys_adr_v  translation probe
//                pbl_regset, pbl          pebble register set and table
//                region_dat               region table word
//                pte_size                 PTE size from page-table type
//                resp_v/resp_rdy/resp_dat/resp_tid/resp_pri/resp_err
//  Revision    : 1.0 - initial release
// ============================================================================
module mmu_reg_read_pipe
    import mmu_pkg::*;
#(
    parameter int DW         = 256,
    parameter int AW         = 14,
    parameter int RDEPTH     = 4,
    parameter int READ_CLEAR = 1,
    parameter int NPBL       = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_v,
    output logic              req_rdy,
    input  logic [AW-1:0]     req_adr,
    input  logic [15:0]       req_tid,
    input  logic [3:0]        req_pri,
    input  logic              cfg_ack,
    input  logic [DW-1:0]     cfg_dat,
    input  logic [15:0]       cfg_tid,
    input  logic [63:0]       fault_adr,
    input  logic [63:0]       fault_seg,
    input  logic [15:0]       fault_asid,
    input  logic              fault_v,
    output logic              fault_clr,
    input  logic [63:0]       ptbr,
    input  logic [63:0]       ptattr,
    input  logic [63:0]       virt_adr,
    input  logic [63:0]       phys_adr,
    input  logic              phys_adr_v,
    input  logic [4:0]        pbl_regset,
    input  logic [NPBL*16-1:0] pbl,
    input  logic [255:0]      region_dat,
    output logic [1:0]        pte_size,
    output logic              resp_v,
    input  logic              resp_rdy,
    output logic [DW-1:0]     resp_dat,
    output logic [15:0]       resp_tid,
    output logic [3:0]        resp_pri,
    output logic              resp_err
);

    localparam int CW = $clog2(RDEPTH) + 1;
    // Register reads may only claim RDEPTH-1 slots; the last is kept for cfg_ack.
    localparam logic [CW:0] c_credit_lim = (CW+1)'(RDEPTH - 2);

    // S0 request registers
    logic              r_s0_v;
    logic [AW-1:0]     r_s0_adr;
    logic [15:0]       r_s0_tid;
    logic [3:0]        r_s0_pri;
    logic [1:0]        r_pte_size;

    logic              w_req_fire;
    logic              w_pop;
    logic              w_not_empty;
    logic [CW-1:0]     w_fifo_count;
    mmu_rg_e           w_grp;
    logic [63:0]       w_word [4];
    logic [63:0]       w_pbl_word;
    logic [255:0]      w_grp_dat;
    logic [255:0]      w_lane_dat;
    ptattr_t           w_ptattr;
    mmu_rd_resp_t      w_cfg_resp;
    mmu_rd_resp_t      w_reg_resp;
    mmu_rd_resp_t      w_head;
    logic [MMU_RESP_BITS-1:0] w_head_bits;

    // ------------------------------------------------------------------
    // Credit check: S0 is the only in-flight stage, S1 pushes unconditionally.
    // ------------------------------------------------------------------
    assign req_rdy    = ~rst && (({1'b0, w_fifo_count} + (CW+1)'(r_s0_v)) <= c_credit_lim);
    assign w_req_fire = req_v && req_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_v   <= 1'b0;
            r_s0_adr <= '0;
            r_s0_tid <= '0;
            r_s0_pri <= '0;
        end else begin
            r_s0_v <= w_req_fire;
            if (w_req_fire) begin
                r_s0_adr <= req_adr;
                r_s0_tid <= req_tid;
                r_s0_pri <= req_pri;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: group build
    // ------------------------------------------------------------------
    assign w_grp    = mmu_rg_decode(r_s0_adr[13:0]);
    assign w_ptattr = ptattr;

    // Pebble word: entries adr[6:3]*4 .. +3, lowest entry in the low bits.
    // Entries beyond NPBL read as zero.
    always_comb begin
        w_pbl_word = '0;
        for (int e = 0; e < NPBL; e++) begin
            if ((e / 4) == int'(r_s0_adr[6:3])) begin
                w_pbl_word[(e % 4)*16 +: 16] = pbl[e*16 +: 16];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_word[i] = '0;
        end
        case (w_grp)
            MMU_RG_FAULT: begin
                w_word[0] = fault_adr;
                w_word[2] = fault_seg;
            end
            MMU_RG_PTBR: begin
                w_word[0] = {fault_asid, 48'b0};
                w_word[1] = ptbr;
                w_word[3] = ptattr;
            end
            MMU_RG_PROBE: begin
                w_word[0] = virt_adr;
                w_word[2] = phys_adr;
            end
            MMU_RG_PVALID: begin
                w_word[0] = {63'b0, phys_adr_v};
                w_word[1] = {59'b0, pbl_regset};
            end
            MMU_RG_PBL: begin
                for (int i = 0; i < 4; i++) begin
                    w_word[i] = w_pbl_word;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_grp_dat = (w_grp == MMU_RG_REGION) ? region_dat
                     : {w_word[3], w_word[2], w_word[1], w_word[0]};

    // Lane select down to DW bits, zero-extended into the FIFO record.
    generate
        if (DW == 256) begin : g_lane256
            assign w_lane_dat = w_grp_dat;
        end else if (DW == 128) begin : g_lane128
            assign w_lane_dat = {128'b0, r_s0_adr[4] ? w_grp_dat[255:128] : w_grp_dat[127:0]};
        end else begin : g_lane64
            assign w_lane_dat = {192'b0, w_grp_dat[64*r_s0_adr[4:3] +: 64]};
        end
    endgenerate

    always_comb begin
        w_reg_resp     = '0;
        w_reg_resp.dat = w_lane_dat;
        w_reg_resp.tid = r_s0_tid;
        w_reg_resp.pri = r_s0_pri;
        w_reg_resp.err = (w_grp == MMU_RG_NONE);
    end

    always_comb begin
        w_cfg_resp     = '0;
        w_cfg_resp.dat = MMU_RESP_W'(cfg_dat);
        w_cfg_resp.tid = cfg_tid;
    end

    // Fault data is sampled this cycle; the clear takes effect afterwards.
    assign fault_clr = (READ_CLEAR != 0) && r_s0_v && (w_grp == MMU_RG_FAULT) && fault_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pte_size <= _8B_PTE;
        end else if (r_s0_v && (w_grp == MMU_RG_PTBR)) begin
            r_pte_size <= (w_ptattr.typ == I386) ? _4B_PTE : _8B_PTE;
        end
    end

    assign pte_size = r_pte_size;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign w_pop = w_not_empty && resp_rdy;

    mmu_resp_fifo #(
        .RDEPTH (RDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr0_en    (cfg_ack),
        .wr0_data  (w_cfg_resp),
        .wr1_en    (r_s0_v),
        .wr1_data  (w_reg_resp),
        .rd_en     (w_pop),
        .rd_data   (w_head_bits),
        .not_empty (w_not_empty),
        .count     (w_fifo_count)
    );

    assign w_head   = w_head_bits;
    assign resp_v   = w_not_empty;
    assign resp_dat = w_head.dat[DW-1:0];
    assign resp_tid = w_head.tid;
    assign resp_pri = w_head.pri;
    assign resp_err = w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_mmu_reg_read_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmu_reg_read_pipe
//  Description : Directed self-checking bench for mmu_reg_read_pipe. One
//                256-bit instance carries most scenarios, a 64-bit instance
//                covers lane select and pte_size.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_reg_read_pipe;
    import mmu_pkg::*;

    logic         clk;
    logic         rst;
    logic         req_v, req_v64;
    logic         req_rdy, req_rdy64;
    logic [13:0]  req_adr;
    logic [15:0]  req_tid;
    logic [3:0]   req_pri;
    logic         cfg_ack;
    logic [255:0] cfg_dat;
    logic [63:0]  cfg_dat64;
    logic [15:0]  cfg_tid;
    logic [63:0]  fault_adr, fault_seg;
    logic [15:0]  fault_asid;
    logic         fault_v;
    logic         fault_clr, fault_clr64;
    logic [63:0]  ptbr, ptattr, virt_adr, phys_adr;
    logic         phys_adr_v;
    logic [4:0]   pbl_regset;
    logic [255:0] pbl;
    logic [255:0] region_dat;
    logic [1:0]   pte_size, pte_size64;
    logic         resp_v, resp_v64;
    logic         resp_rdy;
    logic [255:0] resp_dat;
    logic [63:0]  resp_dat64;
    logic [15:0]  resp_tid, resp_tid64;
    logic [3:0]   resp_pri, resp_pri64;
    logic         resp_err, resp_err64;

    int total = 0;
    int bad   = 0;

    assign cfg_dat64 = cfg_dat[63:0];

    mmu_reg_read_pipe #(.DW(256)) dut (
        .clk(clk), .rst(rst), .req_v(req_v), .req_rdy(req_rdy), .req_adr(req_adr),
        .req_tid(req_tid), .req_pri(req_pri), .cfg_ack(cfg_ack), .cfg_dat(cfg_dat),
        .cfg_tid(cfg_tid), .fault_adr(fault_adr), .fault_seg(fault_seg),
        .fault_asid(fault_asid), .fault_v(fault_v), .fault_clr(fault_clr), .ptbr(ptbr),
        .ptattr(ptattr), .virt_adr(virt_adr), .phys_adr(phys_adr), .phys_adr_v(phys_adr_v),
        .pbl_regset(pbl_regset), .pbl(pbl), .region_dat(region_dat), .pte_size(pte_size),
        .resp_v(resp_v), .resp_rdy(resp_rdy), .resp_dat(resp_dat), .resp_tid(resp_tid),
        .resp_pri(resp_pri), .resp_err(resp_err)
    );

    mmu_reg_read_pipe #(.DW(64)) dut64 (
        .clk(clk), .rst(rst), .req_v(req_v64), .req_rdy(req_rdy64), .req_adr(req_adr),
        .req_tid(req_tid), .req_pri(req_pri), .cfg_ack(cfg_ack), .cfg_dat(cfg_dat64),
        .cfg_tid(cfg_tid), .fault_adr(fault_adr), .fault_seg(fault_seg),
        .fault_asid(fault_asid), .fault_v(fault_v), .fault_clr(fault_clr64), .ptbr(ptbr),
        .ptattr(ptattr), .virt_adr(virt_adr), .phys_adr(phys_adr), .phys_adr_v(phys_adr_v),
        .pbl_regset(pbl_regset), .pbl(pbl), .region_dat(region_dat), .pte_size(pte_size64),
        .resp_v(resp_v64), .resp_rdy(1'b1), .resp_dat(resp_dat64), .resp_tid(resp_tid64),
        .resp_pri(resp_pri64), .resp_err(resp_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single read through the 256-bit instance with resp_rdy held high.
    task automatic rd(input logic [13:0] adr, input logic [15:0] tid,
                      output logic [255:0] dat, output logic err,
                      output logic [15:0] rtid, output logic clr_seen);
        int n;
        clr_seen = 1'b0;
        dat      = '0;
        err      = 1'b0;
        rtid     = '0;
        req_adr  = adr;
        req_tid  = tid;
        req_pri  = 4'h5;
        req_v    = 1'b1;
        #1;
        n = 0;
        while (!req_rdy && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_v = 1'b0;
        n = 0;
        while (!resp_v && n < 20) begin
            clr_seen = clr_seen | fault_clr;
            tick();
            n++;
        end
        check("rd_resp_v", resp_v, 1'b1);
        dat  = resp_dat;
        err  = resp_err;
        rtid = resp_tid;
        tick();
    endtask

    logic [255:0] d;
    logic         e;
    logic         clr;
    logic [15:0]  t;
    int           n_acc;
    int           n_resp;
    logic         acc;
    logic [15:0]  exp_tids [4];

    initial begin
        rst        = 1'b1;
        req_v      = 1'b0;
        req_v64    = 1'b0;
        req_adr    = '0;
        req_tid    = '0;
        req_pri    = '0;
        cfg_ack    = 1'b0;
        cfg_dat    = '0;
        cfg_tid    = '0;
        fault_adr  = 64'h1234;
        fault_seg  = 64'h55;
        fault_asid = 16'hBEEF;
        fault_v    = 1'b1;
        ptbr       = 64'hABC0;
        ptattr     = {60'h0, I386};
        virt_adr   = 64'h1111;
        phys_adr   = 64'h2222;
        phys_adr_v = 1'b1;
        pbl_regset = 5'h0A;
        for (int i = 0; i < 16; i++) pbl[i*16 +: 16] = 16'hA000 + 16'(i);
        region_dat = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                      64'h1122334455667788, 64'h99AABBCCDDEEFF00};
        resp_rdy   = 1'b1;

        // Reset state
        #3;
        check("rst_resp_v", resp_v, 1'b0);
        check("rst_req_rdy", req_rdy, 1'b0);
        check("rst_fault_clr", fault_clr, 1'b0);
        check("rst_resp_dat", resp_dat, 256'h0);
        check("rst_pte_size", pte_size, _8B_PTE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_req_rdy", req_rdy, 1'b1);
        tick();

        // Fault group read: latency 2, single fault_clr pulse
        req_adr = 14'h3F00; req_tid = 16'h0001; req_pri = 4'h3; req_v = 1'b1;
        #1;
        check("f_req_rdy", req_rdy, 1'b1);
        tick();
        req_v = 1'b0;
        check("f_clr_s1", fault_clr, 1'b1);
        check("f_v_early", resp_v, 1'b0);
        tick();
        check("f_resp_v", resp_v, 1'b1);
        check("f_dat", resp_dat, {64'h0, 64'h55, 64'h0, 64'h1234});
        check("f_tid", resp_tid, 16'h0001);
        check("f_pri", resp_pri, 4'h3);
        check("f_err", resp_err, 1'b0);
        check("f_clr_off", fault_clr, 1'b0);
        tick();
        check("f_popped", resp_v, 1'b0);

        // No clear pulse when the fault record is not valid
        fault_v = 1'b0;
        rd(14'h3F00, 16'h0002, d, e, t, clr);
        check("nf_clr", clr, 1'b0);
        check("nf_dat", d, {64'h0, 64'h55, 64'h0, 64'h1234});
        fault_v = 1'b1;

        // 64-bit lane: 0x3F28 selects word 1 = ptbr; pte_size follows typ
        req_adr = 14'h3F28; req_tid = 16'h0003; req_v64 = 1'b1;
        tick();
        req_v64 = 1'b0;
        tick();
        check("l64_v", resp_v64, 1'b1);
        check("l64_dat", resp_dat64, 64'hABC0);
        check("l64_err", resp_err64, 1'b0);
        check("l64_pte4", pte_size64, _4B_PTE);
        ptattr = {60'h0, 4'd0};
        tick();
        check("l64_pte_hold", pte_size64, _4B_PTE);
        req_tid = 16'h0004; req_v64 = 1'b1;
        tick();
        req_v64 = 1'b0;
        tick();
        check("l64_v2", resp_v64, 1'b1);
        check("l64_dat2", resp_dat64, 64'hABC0);
        check("l64_pte8", pte_size64, _8B_PTE);
        tick();

        // Map coverage on the 256-bit instance
        rd(14'h0100, 16'h0010, d, e, t, clr);
        check("unm_dat", d, 256'h0);
        check("unm_err", e, 1'b1);
        rd(14'h3C05, 16'h0011, d, e, t, clr);
        check("reg_dat", d, region_dat);
        check("reg_err", e, 1'b0);
        check("reg_tid", t, 16'h0011);
        rd(14'h3B08, 16'h0012, d, e, t, clr);
        check("pbl_dat", d, {4{64'hA007_A006_A005_A004}});
        rd(14'h3F60, 16'h0013, d, e, t, clr);
        check("pv_dat", d, {64'h0, 64'h0, 64'h0A, 64'h1});
        rd(14'h3F40, 16'h0014, d, e, t, clr);
        check("prb_dat", d, {64'h0, 64'h2222, 64'h0, 64'h1111});
        rd(14'h3F20, 16'h0015, d, e, t, clr);
        check("ptb_dat", d, {64'h0, 64'h0, 64'hABC0, 64'hBEEF_0000_0000_0000});

        // Back-pressure: three reads fit (one slot kept for cfg), then drain five
        resp_rdy = 1'b0;
        n_acc = 0;
        req_adr = 14'h3F40;
        for (int c = 0; c < 6; c++) begin
            req_tid = 16'h0020 + 16'(n_acc);
            req_v   = 1'b1;
            #1;
            acc = req_rdy;
            tick();
            if (acc) n_acc++;
        end
        check("bp_accepted", n_acc, 3);
        #1;
        check("bp_rdy_low", req_rdy, 1'b0);
        check("bp_head_tid", resp_tid, 16'h0020);
        resp_rdy = 1'b1;
        n_resp = 0;
        for (int c = 0; c < 40 && n_resp < 5; c++) begin
            req_v   = (n_acc < 5);
            req_tid = 16'h0020 + 16'(n_acc);
            #1;
            acc = req_v && req_rdy;
            if (resp_v) begin
                check("bp_tid", resp_tid, 16'h0020 + 16'(n_resp));
                n_resp++;
            end
            tick();
            if (acc) n_acc++;
        end
        req_v = 1'b0;
        check("bp_count", n_resp, 5);
        tick();
        check("bp_empty", resp_v, 1'b0);

        // cfg_ack coinciding with the S1 push while two reads are queued
        resp_rdy = 1'b0;
        req_adr = 14'h3F40; req_pri = 4'h5; req_v = 1'b1;
        req_tid = 16'h0030; tick();
        req_tid = 16'h0031; tick();
        req_tid = 16'h0032; tick();
        req_v   = 1'b0;
        cfg_ack = 1'b1; cfg_tid = 16'h0077; cfg_dat = 256'hC0FFEE;
        tick();
        cfg_ack = 1'b0;
        check("cfg_rdy_full", req_rdy, 1'b0);
        exp_tids[0] = 16'h0030; exp_tids[1] = 16'h0031;
        exp_tids[2] = 16'h0077; exp_tids[3] = 16'h0032;
        resp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("cfg_v", resp_v, 1'b1);
            check("cfg_tid", resp_tid, exp_tids[k]);
            if (k == 2) begin
                check("cfg_dat", resp_dat, 256'hC0FFEE);
                check("cfg_pri", resp_pri, 4'h0);
            end
            tick();
        end
        check("cfg_drained", resp_v, 1'b0);

        // Reset with three queued responses
        resp_rdy = 1'b0;
        req_v = 1'b1;
        req_tid = 16'h0040; tick();
        req_tid = 16'h0041; tick();
        req_tid = 16'h0042; tick();
        req_v = 1'b0;
        tick();
        check("mr_queued", resp_v, 1'b1);
        rst = 1'b1;
        #1;
        check("mr_resp_v", resp_v, 1'b0);
        check("mr_req_rdy", req_rdy, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mr_rdy_rel", req_rdy, 1'b1);
        tick();
        check("mr_no_stale", resp_v, 1'b0);
        resp_rdy = 1'b1;
        rd(14'h3F40, 16'h0050, d, e, t, clr);
        check("mr_after_tid", t, 16'h0050);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
